// File: rtl/sysbus_pkg.sv
// Shared constants, tag layout and FSM state type for the system-bus memory responder.
package sysbus_pkg;

    localparam logic       SYSBUS_READ   = 1'b1;
    localparam logic       SYSBUS_WRITE  = 1'b0;
    localparam logic [3:0] SYSBUS_MEMORY = 4'h1;

    localparam int unsigned TAG_RW_BIT  = 12;
    localparam int unsigned TAG_TGT_MSB = 11;
    localparam int unsigned TAG_TGT_LSB = 8;
    localparam int unsigned TAG_ID_MSB  = 7;

    localparam int unsigned LINE_BEATS    = 8;
    localparam int unsigned LINE_BYTES    = 64;
    localparam int unsigned BEAT_BITS     = 3;
    localparam int unsigned LINE_OFF_BITS = 6;

    typedef enum logic [1:0] {
        StIdle,
        StRlat,
        StRburst,
        StWdata
    } resp_state_t;

endpackage

// File: rtl/sysbus_mem_array.sv
// Line-organised 64-bit word store: combinational read, synchronous write.
// Lines past the end of the array read as zero and ignore writes.
module sysbus_mem_array
    import sysbus_pkg::*;
#(
    parameter int unsigned MEM_WORDS  = 4096,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned ADDR_WIDTH = 64
) (
    input  logic                                clk,
    input  logic [ADDR_WIDTH-LINE_OFF_BITS-1:0] line,
    input  logic [BEAT_BITS-1:0]                beat,
    output logic [DATA_WIDTH-1:0]               rdata,
    input  logic                                we,
    input  logic [DATA_WIDTH-1:0]               wdata
);

    localparam int unsigned IdxW  = $clog2(MEM_WORDS);
    localparam int unsigned LineW = ADDR_WIDTH - LINE_OFF_BITS;
    localparam logic [LineW-1:0] NumLines = LineW'(MEM_WORDS / LINE_BEATS);

    logic [DATA_WIDTH-1:0] mem [MEM_WORDS];
    logic                  in_range;
    logic [IdxW-1:0]       idx;

    assign in_range = (line < NumLines);
    assign idx      = IdxW'({line, beat});
    assign rdata    = in_range ? mem[idx] : '0;

    always_ff @(posedge clk) begin
        if (we && in_range) begin
            mem[idx] <= wdata;
        end
    end

endmodule

// File: rtl/sysbus_mem_responder.sv
// Memory-side system-bus responder serving 64-byte lines as 8 tagged beats.
// Define SYSBUS_RESP_TRACE_EN to print every acked read beat and written beat.
module sysbus_mem_responder
    import sysbus_pkg::*;
#(
    parameter int unsigned BUS_DATA_WIDTH = 64,
    parameter int unsigned BUS_TAG_WIDTH  = 13,
    parameter int unsigned MEM_WORDS      = 4096,
    parameter int unsigned READ_LATENCY   = 4
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      bus_reqcyc,
    input  logic [BUS_DATA_WIDTH-1:0] bus_req,
    input  logic [BUS_TAG_WIDTH-1:0]  bus_reqtag,
    output logic                      bus_reqack,
    output logic                      bus_respcyc,
    output logic [BUS_DATA_WIDTH-1:0] bus_resp,
    output logic [BUS_TAG_WIDTH-1:0]  bus_resptag,
    input  logic                      bus_respack
);

    localparam int unsigned LineW = BUS_DATA_WIDTH - LINE_OFF_BITS;
    localparam int unsigned LatW  = $clog2(READ_LATENCY + 1);

    resp_state_t              state_q, state_d;
    logic [BUS_TAG_WIDTH-1:0] tag_q, tag_d;
    logic [LineW-1:0]         line_q, line_d;
    logic [BEAT_BITS-1:0]     beat_q, beat_d;
    logic [LatW-1:0]          lat_q, lat_d;
    logic                     reqack_q, reqack_d;

    logic                      take;
    logic                      target_ok;
    logic                      mem_we;
    logic [BUS_DATA_WIDTH-1:0] mem_rdata;

    // The ack trails consumption by a cycle, so the beat still held during the ack
    // cycle is the one already consumed and must not be taken twice.
    assign take      = bus_reqcyc && !reqack_q;
    assign target_ok = (tag_q[TAG_TGT_MSB:TAG_TGT_LSB] == SYSBUS_MEMORY);

    sysbus_mem_array #(
        .MEM_WORDS  (MEM_WORDS),
        .DATA_WIDTH (BUS_DATA_WIDTH),
        .ADDR_WIDTH (BUS_DATA_WIDTH)
    ) u_array (
        .clk   (clk),
        .line  (line_q),
        .beat  (beat_q),
        .rdata (mem_rdata),
        .we    (mem_we),
        .wdata (bus_req)
    );

    always_comb begin
        state_d  = state_q;
        tag_d    = tag_q;
        line_d   = line_q;
        beat_d   = beat_q;
        lat_d    = lat_q;
        reqack_d = 1'b0;
        mem_we   = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (take) begin
                    tag_d    = bus_reqtag;
                    line_d   = bus_req[BUS_DATA_WIDTH-1:LINE_OFF_BITS];
                    beat_d   = '0;
                    reqack_d = 1'b1;
                    if (bus_reqtag[TAG_RW_BIT] == SYSBUS_READ) begin
                        state_d = StRlat;
                        lat_d   = LatW'(READ_LATENCY);
                    end else begin
                        state_d = StWdata;
                    end
                end
            end
            StRlat: begin
                if (lat_q <= LatW'(1)) begin
                    state_d = StRburst;
                    lat_d   = '0;
                end else begin
                    lat_d = lat_q - LatW'(1);
                end
            end
            StRburst: begin
                if (bus_respack) begin
                    if (beat_q == BEAT_BITS'(LINE_BEATS - 1)) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            StWdata: begin
                if (take) begin
                    mem_we   = target_ok;
                    reqack_d = 1'b1;
                    if (beat_q == BEAT_BITS'(LINE_BEATS - 1)) begin
                        state_d = StIdle;
                        beat_d  = '0;
                    end else begin
                        beat_d = beat_q + BEAT_BITS'(1);
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StIdle;
            tag_q    <= '0;
            line_q   <= '0;
            beat_q   <= '0;
            lat_q    <= '0;
            reqack_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            tag_q    <= tag_d;
            line_q   <= line_d;
            beat_q   <= beat_d;
            lat_q    <= lat_d;
            reqack_q <= reqack_d;
        end
    end

    assign bus_reqack  = reqack_q;
    assign bus_respcyc = (state_q == StRburst);
    assign bus_resp    = (bus_respcyc && target_ok) ? mem_rdata : '0;
    assign bus_resptag = bus_respcyc ? tag_q : '0;

`ifdef SYSBUS_RESP_TRACE_EN
    always_ff @(posedge clk) begin
        if (reset && bus_respcyc && bus_respack) begin
            $display("R tag=%h addr=%h data=%h", tag_q,
                     {line_q, beat_q, 3'b000}, bus_resp);
        end
        if (reset && mem_we) begin
            $display("W addr=%h data=%h", {line_q, beat_q, 3'b000}, bus_req);
        end
    end
`endif

endmodule

// File: tb/tb_sysbus_mem_responder.sv
// Scoreboard bench for sysbus_mem_responder: a word model predicts every read beat.
module tb_sysbus_mem_responder;

    localparam int unsigned MEM_WORDS    = 4096;
    localparam int unsigned READ_LATENCY = 4;
    localparam logic [63:0] STRIDE       = 64'h0101010101010101;

    logic        clk = 1'b0;
    logic        reset;
    logic        bus_reqcyc;
    logic [63:0] bus_req;
    logic [12:0] bus_reqtag;
    logic        bus_reqack;
    logic        bus_respcyc;
    logic [63:0] bus_resp;
    logic [12:0] bus_resptag;
    logic        bus_respack;

    int checks   = 0;
    int failures = 0;
    int ack_cnt  = 0;
    int resp_cnt = 0;

    logic [63:0] exp_q[$];
    logic [12:0] exp_tag_q[$];
    logic [63:0] model [longint];

    sysbus_mem_responder #(
        .BUS_DATA_WIDTH (64),
        .BUS_TAG_WIDTH  (13),
        .MEM_WORDS      (MEM_WORDS),
        .READ_LATENCY   (READ_LATENCY)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus_reqcyc  (bus_reqcyc),
        .bus_req     (bus_req),
        .bus_reqtag  (bus_reqtag),
        .bus_reqack  (bus_reqack),
        .bus_respcyc (bus_respcyc),
        .bus_resp    (bus_resp),
        .bus_resptag (bus_resptag),
        .bus_respack (bus_respack)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (bus_reqack === 1'b1) ack_cnt <= ack_cnt + 1;
        if (bus_respcyc === 1'b1) resp_cnt <= resp_cnt + 1;
    end

    function automatic bit line_ok(input logic [63:0] addr, input logic [12:0] tag);
        return (tag[11:8] == 4'h1) && ((addr >> 6) < 64'(MEM_WORDS / 8));
    endfunction

    task automatic send_beat(input logic [63:0] data, input logic [12:0] tag);
        int n = 0;
        bus_reqcyc = 1'b1;
        bus_req    = data;
        bus_reqtag = tag;
        do begin
            @(negedge clk);
            n++;
        end while (bus_reqack !== 1'b1 && n < 50);
        bus_reqcyc = 1'b0;
        if (bus_reqack !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL reqack_timeout: reqack=%b required 1", bus_reqack);
        end
    endtask

    task automatic write_line(input logic [63:0] addr, input logic [12:0] tag,
                              input logic [63:0] base_val, input int gap_after);
        logic [63:0] wbase;
        wbase = (addr >> 3) & ~64'd7;
        send_beat(addr, tag);
        for (int i = 0; i < 8; i++) begin
            send_beat(base_val + 64'(i), tag);
            if (line_ok(addr, tag)) model[longint'(wbase + 64'(i))] = base_val + 64'(i);
            if (i == gap_after) repeat (2) @(negedge clk);
        end
    endtask

    task automatic push_read_exp(input logic [63:0] addr, input logic [12:0] tag);
        logic [63:0] rbase;
        rbase = (addr >> 3) & ~64'd7;
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(line_ok(addr, tag) ? model[longint'(rbase + 64'(i))] : 64'd0);
            exp_tag_q.push_back(tag);
        end
    endtask

    task automatic recv_line(input int stall_beat, input int stall_cycles, output int lat);
        int n = 0;
        logic [63:0] exp;
        logic [12:0] exp_tag;
        lat = -1;
        while (bus_respcyc !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (bus_respcyc !== 1'b1) begin
            checks++;
            failures++;
            $display("FAIL resp_timeout: respcyc=%b required 1", bus_respcyc);
            return;
        end
        lat = n;
        for (int b = 0; b < 8; b++) begin
            checks++;
            if (bus_respcyc !== 1'b1 || exp_q.size() == 0) begin
                failures++;
                $display("FAIL beat_missing: beat %0d respcyc=%b queued=%0d", b,
                         bus_respcyc, exp_q.size());
                break;
            end
            exp     = exp_q.pop_front();
            exp_tag = exp_tag_q.pop_front();
            checks++;
            if (bus_resp !== exp) begin
                failures++;
                $display("FAIL beat_data: beat %0d got %h required %h", b, bus_resp, exp);
            end
            checks++;
            if (bus_resptag !== exp_tag) begin
                failures++;
                $display("FAIL beat_tag: beat %0d got %h required %h", b, bus_resptag, exp_tag);
            end
            if (b == stall_beat) begin
                bus_respack = 1'b0;
                for (int s = 0; s < stall_cycles; s++) begin
                    @(negedge clk);
                    checks++;
                    if (bus_respcyc !== 1'b1 || bus_resp !== exp) begin
                        failures++;
                        $display("FAIL stall_hold: cycle %0d respcyc=%b data %h required %h",
                                 s, bus_respcyc, bus_resp, exp);
                    end
                end
            end
            bus_respack = 1'b1;
            @(negedge clk);
            bus_respack = 1'b0;
        end
        checks++;
        if (bus_respcyc !== 1'b0) begin
            failures++;
            $display("FAIL burst_end: respcyc=%b required 0", bus_respcyc);
        end
    endtask

    task automatic read_line(input logic [63:0] addr, input logic [12:0] tag,
                             input int stall_beat, input int stall_cycles, output int lat);
        push_read_exp(addr, tag);
        send_beat(addr, tag);
        recv_line(stall_beat, stall_cycles, lat);
    endtask

    task automatic test_reset();
        reset       = 1'b0;
        bus_reqcyc  = 1'b0;
        bus_req     = '0;
        bus_reqtag  = '0;
        bus_respack = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (bus_reqack !== 1'b0 || bus_respcyc !== 1'b0) begin
            failures++;
            $display("FAIL reset_handshake: reqack=%b respcyc=%b required 0 0",
                     bus_reqack, bus_respcyc);
        end
        checks++;
        if (bus_resp !== 64'd0 || bus_resptag !== 13'd0) begin
            failures++;
            $display("FAIL reset_data: resp=%h tag=%h required 0 0", bus_resp, bus_resptag);
        end
        reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_read();
        int lat;
        int a0;
        write_line(64'h0, 13'h0100, 64'd0, -1);
        write_line(64'h40, 13'h0100, 64'd0, -1);
        // Overwrite the preload so word[k] = k * 0x0101...01.
        for (int k = 0; k < 16; k++) model[longint'(k)] = 64'(k) * STRIDE;
        send_beat(64'h0, 13'h0100);
        for (int k = 0; k < 8; k++) send_beat(64'(k) * STRIDE, 13'h0100);
        send_beat(64'h40, 13'h0100);
        for (int k = 8; k < 16; k++) send_beat(64'(k) * STRIDE, 13'h0100);
        repeat (2) @(negedge clk);
        a0 = ack_cnt;
        read_line(64'h40, 13'h1105, -1, 0, lat);
        checks++;
        if (lat != READ_LATENCY) begin
            failures++;
            $display("FAIL read_latency: got %0d required %0d", lat, READ_LATENCY);
        end
        @(negedge clk);
        checks++;
        if (ack_cnt - a0 != 1) begin
            failures++;
            $display("FAIL read_acks: got %0d required 1", ack_cnt - a0);
        end
    endtask

    task automatic test_stall();
        int lat;
        read_line(64'h40, 13'h1105, 3, 5, lat);
    endtask

    task automatic test_write_gap();
        int a0;
        int r0;
        int lat;
        a0 = ack_cnt;
        r0 = resp_cnt;
        write_line(64'h80, 13'h0100, 64'hA0, 4);
        repeat (2) @(negedge clk);
        checks++;
        if (ack_cnt - a0 != 9) begin
            failures++;
            $display("FAIL write_acks: got %0d required 9", ack_cnt - a0);
        end
        checks++;
        if (resp_cnt != r0) begin
            failures++;
            $display("FAIL write_no_resp: got %0d beats required 0", resp_cnt - r0);
        end
        read_line(64'h80, 13'h1105, -1, 0, lat);
    endtask

    task automatic test_boundaries();
        int lat;
        read_line(64'h7, 13'h1001, -1, 0, lat);
        read_line(64'(MEM_WORDS) * 8, 13'h1102, -1, 0, lat);
        // Wrong target: write must be dropped and reads of it return zero.
        write_line(64'h0, 13'h0200, 64'hDEAD0000, -1);
        read_line(64'h0, 13'h1203, -1, 0, lat);
        read_line(64'h0, 13'h1104, -1, 0, lat);
    endtask

    task automatic test_reset_mid_burst();
        int lat;
        int n = 0;
        logic [63:0] exp;
        push_read_exp(64'h40, 13'h1106);
        send_beat(64'h40, 13'h1106);
        while (bus_respcyc !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        for (int b = 0; b < 5; b++) begin
            exp = exp_q.pop_front();
            void'(exp_tag_q.pop_front());
            checks++;
            if (bus_respcyc !== 1'b1 || bus_resp !== exp) begin
                failures++;
                $display("FAIL pre_reset_beat: beat %0d got %h required %h", b, bus_resp, exp);
            end
            bus_respack = 1'b1;
            @(negedge clk);
            bus_respack = 1'b0;
        end
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (bus_respcyc !== 1'b0 || bus_reqack !== 1'b0) begin
            failures++;
            $display("FAIL mid_reset: respcyc=%b reqack=%b required 0 0",
                     bus_respcyc, bus_reqack);
        end
        reset = 1'b1;
        exp_q.delete();
        exp_tag_q.delete();
        @(negedge clk);
        read_line(64'h40, 13'h1107, -1, 0, lat);
    endtask

    task automatic test_back_to_back();
        int lat;
        int a0;
        int n = 0;
        push_read_exp(64'h0, 13'h1108);
        send_beat(64'h0, 13'h1108);
        while (bus_respcyc !== 1'b1 && n < 200) begin
            @(negedge clk);
            n++;
        end
        push_read_exp(64'h40, 13'h1109);
        a0 = ack_cnt;
        bus_reqcyc = 1'b1;
        bus_req    = 64'h40;
        bus_reqtag = 13'h1109;
        recv_line(-1, 0, lat);
        checks++;
        if (ack_cnt != a0) begin
            failures++;
            $display("FAIL ack_during_burst: got %0d acks required 0", ack_cnt - a0);
        end
        send_beat(64'h40, 13'h1109);
        recv_line(-1, 0, lat);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_left: got %0d beats pending required 0", exp_q.size());
        end
    endtask

    initial begin
        test_reset();
        test_read();
        test_stall();
        test_write_gap();
        test_boundaries();
        test_reset_mid_burst();
        test_back_to_back();
        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
